// File: rtl/half_adder_exerciser.sv
// half_adder_exerciser
// Drives every a/b combination of a half adder in order: 00, 01, 10, 11.
// It compares each sum/carry response against the golden function, counts
// mismatches with saturation and reports a pass flag at the end of each run.
// A start/done handshake runs PASSES sweeps. Each vector is held for
// SETTLE_CYCLES cycles before the check cycle.
// Optional first-error log: define HA_EXERCISER_ERRLOG_EN to add the
// first_err_valid / first_err_vec / first_err_resp ports and their registers.
module half_adder_exerciser #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             a,
  output logic             b,
  input  logic             sum,
  input  logic             carry,
  output logic [1:0]       vec_idx,
  output logic [ERR_W-1:0] err_count
`ifdef HA_EXERCISER_ERRLOG_EN
  ,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec,
  output logic [1:0]       first_err_resp
`endif
);

  // Counter widths; both parameters are at least 1, so both widths are >= 1.
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = $clog2(PASSES + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;     // cycles spent in DRIVE for this vector
  logic [PASS_W-1:0]  sweep_q, sweep_d;       // sweeps completed so far in this run
  logic [1:0]         vec_idx_q, vec_idx_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;

`ifdef HA_EXERCISER_ERRLOG_EN
  logic               fe_valid_q, fe_valid_d;
  logic [1:0]         fe_vec_q, fe_vec_d;
  logic [1:0]         fe_resp_q, fe_resp_d;
`endif

  // Golden half-adder response for the operands currently on a/b.
  logic [1:0]       expected_resp;
  logic [1:0]       actual_resp;
  logic             mismatch;
  logic [ERR_W-1:0] err_after_check;

  // Compare the adder response during CHECK; the error count saturates at its maximum.
  always_comb begin
    expected_resp   = {a_q & b_q, a_q ^ b_q};
    actual_resp     = {carry, sum};
    mismatch        = (state_q == S_CHECK) && (actual_resp != expected_resp);
    err_after_check = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_after_check = err_q + 1'b1;
    end
  end

  // Next-state and output logic for the sweep controller.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    sweep_d   = sweep_q;
    vec_idx_d = vec_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
`ifdef HA_EXERCISER_ERRLOG_EN
    fe_valid_d = fe_valid_q;
    fe_vec_d   = fe_vec_q;
    fe_resp_d  = fe_resp_q;
`endif

    case (state_q)
      S_IDLE: begin
        vec_idx_d = 2'd0;
        busy_d    = 1'b0;
        if (start) begin
          // Accept the run: vector 0 goes out next cycle and last run's results are cleared.
          state_d  = S_DRIVE;
          busy_d   = 1'b1;
          settle_d = '0;
          sweep_d  = '0;
          err_d    = '0;
          pass_d   = 1'b0;
`ifdef HA_EXERCISER_ERRLOG_EN
          fe_valid_d = 1'b0;
          fe_vec_d   = 2'd0;
          fe_resp_d  = 2'd0;
`endif
        end
      end

      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = S_CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_CHECK: begin
        err_d = err_after_check;
`ifdef HA_EXERCISER_ERRLOG_EN
        // Only the first mismatch of a run is recorded.
        if (mismatch && !fe_valid_q) begin
          fe_valid_d = 1'b1;
          fe_vec_d   = vec_idx_q;
          fe_resp_d  = actual_resp;
        end
`endif
        if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = S_DRIVE;
        end else if (sweep_q != PASS_LAST) begin
          sweep_d   = sweep_q + 1'b1;
          vec_idx_d = 2'd0;
          state_d   = S_DRIVE;
        end else begin
          // The last check's mismatch is already included in err_after_check.
          state_d   = S_DONE;
          vec_idx_d = 2'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_after_check == '0);
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        vec_idx_d = 2'd0;
      end

      default: begin
        state_d   = S_IDLE;
        vec_idx_d = 2'd0;
        busy_d    = 1'b0;
      end
    endcase

    // The operands always follow the vector index; the index is 0 outside DRIVE/CHECK.
    a_d = vec_idx_d[1];
    b_d = vec_idx_d[0];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      sweep_q   <= '0;
      vec_idx_q <= 2'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      sweep_q   <= sweep_d;
      vec_idx_q <= vec_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

`ifdef HA_EXERCISER_ERRLOG_EN
  // First-error log registers, cleared by reset and by start acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_valid_q <= 1'b0;
      fe_vec_q   <= 2'd0;
      fe_resp_q  <= 2'd0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_vec_q   <= fe_vec_d;
      fe_resp_q  <= fe_resp_d;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_vec   = fe_vec_q;
  assign first_err_resp  = fe_resp_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign a         = a_q;
  assign b         = b_q;
  assign vec_idx   = vec_idx_q;
  assign err_count = err_q;

endmodule

// File: doc/half_adder_exerciser.md
# half_adder_exerciser

Synthesizable stimulus-and-check engine for the half-adder block. It drives the adder's `a`/`b` inputs and samples its `sum`/`carry` outputs, the role the simulation bench plays, so the adder can be self-tested on hardware. A start/done handshake runs one or more sweeps of all four input vectors. The engine compares every response against the golden half-adder function and reports an error count and a pass flag.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range ≥1.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range ≥1.
- `ERR_W`, default 8: width of the error counter.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock; all state changes on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `busy` out 1: high from the cycle after start acceptance through the last CHECK cycle.
- `done` out 1: one-cycle pulse at run completion.
- `pass` out 1: 1 when the last run had zero errors; held until the next start is accepted.
- `a` out 1: adder operand A, registered.
- `b` out 1: adder operand B, registered.
- `sum` in 1: adder sum response.
- `carry` in 1: adder carry response.
- `vec_idx` out 2: current vector index, `{a,b}`.
- `err_count` out ERR_W: count of mismatching vectors, saturating.
- `first_err_valid`, `first_err_vec[1:0]`, `first_err_resp[1:0]` out: present only with `HA_EXERCISER_ERRLOG_EN`.

## Operation
- FSM states are IDLE, DRIVE, CHECK and DONE.
- IDLE:
  - `a`, `b` and `vec_idx` are 0.
  - `start`=1 → DRIVE, with vector 0 applied, `err_count` cleared, `pass` cleared and the pass counter cleared.
- DRIVE:
  - `{a,b}`=`vec_idx` is held for SETTLE_CYCLES cycles, then → CHECK.
- CHECK:
  - `{a,b}` is still held.
  - At the end of the cycle, `{carry,sum}` is compared against expected `{a&b, a^b}`.
  - On mismatch, `err_count` increments and saturates at 2^ERR_W−1.
  - If `vec_idx`<3: increment `vec_idx` → DRIVE.
  - Else if the sweep count < PASSES: `vec_idx` wraps to 0 → DRIVE.
  - Else → DONE.
- DONE:
  - lasts one cycle: `done`=1, `pass`=(`err_count`==0), `a`=`b`=0, then → IDLE.
- `start` is ignored in DRIVE, CHECK and DONE; it is not queued.
- Vector order is 00, 01, 10, 11.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `a`, `b`, `vec_idx` and `err_count` all 0.
- Start accepted at edge T → `busy`=1 and vector 0 on `a`/`b` from cycle T+1.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- Run length: `busy` high for exactly PASSES×4×(SETTLE_CYCLES+1) cycles, immediately followed by the `done` pulse.
- The earliest next start is the cycle after `done`, i.e. in IDLE.
- `err_count` is valid from the cycle after each CHECK; the final value is stable from `done` until the next start.
- Reset mid-run takes effect at the next edge: return to IDLE with every output at its reset value, and no `done` pulse.
- A mismatch on the final vector is counted before `done`/`pass` are evaluated.

## Configuration
- `HA_EXERCISER_ERRLOG_EN` defined: logs the first mismatch of a run.
  - On the first mismatch, capture `first_err_vec`=`vec_idx` and `first_err_resp`=`{carry,sum}`, and set `first_err_valid`.
  - The capture holds until the next start acceptance or reset, both of which clear all three to 0.
  - Later mismatches do not overwrite it.
- Undefined: those three ports and their registers do not exist; all other behaviour is identical.

## Test plan
- Correct adder model, SETTLE_CYCLES=1, PASSES=1, start pulse at cycle 0:
  - `busy` high for 8 cycles;
  - `done` pulse in cycle 9;
  - `err_count`=0 and `pass`=1.
- Carry stuck-at-0 model:
  - `err_count`=1 and `pass`=0;
  - with ERRLOG: `first_err_vec`=2'b11 and `first_err_resp`=2'b00.
- Inverted-sum model, PASSES=2:
  - `err_count`=8 and `pass`=0;
  - with ERRLOG: `first_err_vec`=0 and `first_err_resp`=2'b01.
- Inverted-sum model, ERR_W=2, PASSES=1:
  - `err_count` saturates at 3.
- `start` re-asserted mid-run:
  - no restart; `done` occurs at the original cycle.
- `rst_n` low during CHECK of vector 2:
  - next cycle all outputs are 0, no `done`;
  - a new start then gives a full, correct run.
